// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared types and constants for the CPU bus capture front-end
package cpu_bus_pkg;
  localparam int SYNC_STAGES = 2;
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  dat;
    logic        rw;
  } bus_ev_t;
  typedef enum logic [1:0] {IDLE, HIGH, COMMIT} cap_state_t;
endpackage

// File: rtl/ev_fifo.sv
// ev_fifo: synchronous event FIFO with a sticky flag for pushes dropped while full
module ev_fifo
  import cpu_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  bus_ev_t din,
  input  logic    pop,
  output logic    valid,
  output bus_ev_t head,
  output logic    ovf
);
  localparam int AW = $clog2(DEPTH);
  bus_ev_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] cnt;
  logic full, empty, do_pop, do_push;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  // A pop frees the head slot in the same edge, so a full FIFO can still accept
  assign do_push = push && (!full || do_pop);
  assign valid = !empty;
  assign head = empty ? '0 : mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk)
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (do_push) wr <= wr + AW'(1);
      if (do_pop) rd <= rd + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (push && !do_push) ovf <= 1'b1;
    end
endmodule

// File: rtl/cpu_bus_capture.sv
// cpu_bus_capture: synchronizes the async CPU bus, filters short M2 pulses and
// queues each valid cycle as an event for the mapper register logic.
module cpu_bus_capture
  import cpu_bus_pkg::*;
#(
  parameter int MIN_HI = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int READ_EV = 0
) (
  input  logic        clk,
  input  logic        map_rst_n,
  input  logic        m2,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dat,
  input  logic        cpu_rw,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [15:0] ev_addr,
  output logic [7:0]  ev_dat,
  output logic        ev_rw,
  output logic        ev_ovf,
  output logic [15:0] m2_cnt,
  output logic        glitch
);
  localparam int HW = $clog2(MIN_HI + 1);
  logic [SYNC_STAGES-1:0] m2_sync, rw_sync;
  logic [SYNC_STAGES-1:0][15:0] addr_sync;
  logic [SYNC_STAGES-1:0][7:0] dat_sync;
  logic m2s, m2d, rise, fall, glitch_nx, push;
  cap_state_t state, state_nx;
  logic [HW-1:0] hi_cnt, hi_cnt_nx;
  bus_ev_t cap, cap_nx, head;
  assign m2s = m2_sync[SYNC_STAGES-1];
  assign rise = m2s && !m2d;
  assign fall = !m2s && m2d;
  always_ff @(posedge clk)
    if (!map_rst_n) begin
      m2_sync <= '0;
      rw_sync <= '0;
      addr_sync <= '0;
      dat_sync <= '0;
      m2d <= 1'b0;
    end else begin
      m2_sync <= {m2_sync[SYNC_STAGES-2:0], m2};
      rw_sync <= {rw_sync[SYNC_STAGES-2:0], cpu_rw};
      addr_sync <= {addr_sync[SYNC_STAGES-2:0], cpu_addr};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], cpu_dat};
      m2d <= m2s;
    end
  always_ff @(posedge clk)
    if (!map_rst_n) begin
      state <= IDLE;
      hi_cnt <= '0;
      cap <= '0;
      glitch <= 1'b0;
      m2_cnt <= '0;
    end else begin
      state <= state_nx;
      hi_cnt <= hi_cnt_nx;
      cap <= cap_nx;
      glitch <= glitch_nx;
      m2_cnt <= m2_cnt + 16'(state == COMMIT);
    end
  // Address and direction are latched at the rise; data keeps tracking until the fall
  always_comb begin
    state_nx = state;
    hi_cnt_nx = hi_cnt;
    cap_nx = cap;
    glitch_nx = 1'b0;
    push = 1'b0;
    if (state == HIGH) begin
      if (m2s) begin
        cap_nx.dat = dat_sync[SYNC_STAGES-1];
        hi_cnt_nx = (hi_cnt == HW'(MIN_HI)) ? hi_cnt : hi_cnt + HW'(1);
      end else if (fall) begin
        state_nx = (hi_cnt >= HW'(MIN_HI)) ? COMMIT : IDLE;
        glitch_nx = hi_cnt < HW'(MIN_HI);
      end
    end else begin
      push = (state == COMMIT) && (!cap.rw || READ_EV != 0);
      state_nx = rise ? HIGH : IDLE;
      if (rise) begin
        hi_cnt_nx = HW'(1);
        cap_nx = '{addr: addr_sync[SYNC_STAGES-1], dat: dat_sync[SYNC_STAGES-1], rw: rw_sync[SYNC_STAGES-1]};
      end
    end
  end
  ev_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(map_rst_n),
    .push(push),
    .din(cap),
    .pop(ev_ready),
    .valid(ev_valid),
    .head(head),
    .ovf(ev_ovf)
  );
  assign ev_addr = head.addr;
  assign ev_dat = head.dat;
  assign ev_rw = head.rw;
endmodule

// File: tb/tb_cpu_bus_capture.sv
// tb_cpu_bus_capture: scoreboard bench driving a write-only and a read-enabled instance in parallel
module tb_cpu_bus_capture;
  localparam int MIN_HI = 3;
  logic clk = 1'b0, map_rst_n = 1'b0, m2 = 1'b0, cpu_rw = 1'b0, ev_ready = 1'b0, ready_r = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0] cpu_dat = '0;
  logic ev_valid, ev_rw, ev_ovf, glitch, valid_r, rw_r, ovf_r, glitch_r;
  logic [15:0] ev_addr, m2_cnt, addr_r, cnt_r;
  logic [7:0] ev_dat, dat_r;
  typedef struct {logic [15:0] addr; logic [7:0] dat; logic rw;} ev_t;
  typedef struct {logic [15:0] addr; logic [7:0] dat; logic rw; int hi; int gl; bit ev; bit ev_r;} vec_t;
  ev_t q[$], qr[$];
  vec_t tbl[6];
  int errors = 0, checks = 0, gcnt = 0, exp_cnt = 0, g0, n;

  cpu_bus_capture #(.MIN_HI(MIN_HI), .FIFO_DEPTH(4), .READ_EV(0)) dut (
    .clk(clk), .map_rst_n(map_rst_n), .m2(m2), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat), .cpu_rw(cpu_rw),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_addr(ev_addr), .ev_dat(ev_dat), .ev_rw(ev_rw),
    .ev_ovf(ev_ovf), .m2_cnt(m2_cnt), .glitch(glitch));
  cpu_bus_capture #(.MIN_HI(MIN_HI), .FIFO_DEPTH(4), .READ_EV(1)) dut_r (
    .clk(clk), .map_rst_n(map_rst_n), .m2(m2), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat), .cpu_rw(cpu_rw),
    .ev_valid(valid_r), .ev_ready(ready_r), .ev_addr(addr_r), .ev_dat(dat_r), .ev_rw(rw_r),
    .ev_ovf(ovf_r), .m2_cnt(cnt_r), .glitch(glitch_r));

  always #5 clk = ~clk;
  always @(posedge clk) if (glitch) gcnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw, input int hi, input int lo,
                           input bit pq, input bit pr);
    cpu_addr = a;
    cpu_dat = d;
    cpu_rw = rw;
    m2 = 1'b1;
    if (pq) q.push_back('{a, d, rw});
    if (pr) qr.push_back('{a, d, rw});
    if (hi >= MIN_HI) exp_cnt++;
    repeat (hi) step();
    m2 = 1'b0;
    repeat (lo) step();
  endtask

  task automatic head_chk();
    ev_t e;
    if (ev_valid) begin
      if (q.size() == 0) check("extra_ev", ev_valid, 1'b0);
      else begin
        e = q.pop_front();
        check("ev_addr", ev_addr, e.addr);
        check("ev_dat", ev_dat, e.dat);
        check("ev_rw", ev_rw, e.rw);
      end
    end
    if (valid_r) begin
      if (qr.size() == 0) check("extra_ev_r", valid_r, 1'b0);
      else begin
        e = qr.pop_front();
        check("ev_addr_r", addr_r, e.addr);
        check("ev_dat_r", dat_r, e.dat);
        check("ev_rw_r", rw_r, e.rw);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) begin
      ev_ready = ev_valid;
      ready_r = valid_r;
      head_chk();
      step();
    end
    ev_ready = 1'b0;
    ready_r = 1'b0;
    check("sb_left", q.size(), 0);
    check("sb_left_r", qr.size(), 0);
    check("valid_end", ev_valid, 1'b0);
    check("valid_end_r", valid_r, 1'b0);
  endtask

  task automatic cnt_chk();
    check("m2_cnt", m2_cnt, exp_cnt);
    check("m2_cnt_r", cnt_r, exp_cnt);
  endtask

  task automatic do_reset(input int len);
    map_rst_n = 1'b0;
    repeat (len) step();
    map_rst_n = 1'b1;
    q.delete();
    qr.delete();
    exp_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'h8000, 8'hA5, 1'b0, 3, 0, 1'b1, 1'b1};
    tbl[1] = '{16'h8001, 8'h11, 1'b0, 2, 1, 1'b0, 1'b0};
    tbl[2] = '{16'h4100, 8'h77, 1'b1, 5, 0, 1'b0, 1'b1};
    tbl[3] = '{16'hC000, 8'hFF, 1'b0, 1, 1, 1'b0, 1'b0};
    tbl[4] = '{16'hFFFF, 8'h00, 1'b0, 4, 0, 1'b1, 1'b1};
    tbl[5] = '{16'h0000, 8'h5A, 1'b0, 8, 0, 1'b1, 1'b1};

    do_reset(3);
    check("rst_valid", ev_valid, 1'b0);
    check("rst_ovf", ev_ovf, 1'b0);
    check("rst_cnt", m2_cnt, 16'h0);
    check("rst_glitch", glitch, 1'b0);
    check("rst_addr", ev_addr, 16'h0);
    check("rst_dat", ev_dat, 8'h0);
    check("rst_rw", ev_rw, 1'b0);

    // first event latency, measured from the pin fall
    cpu_cycle(16'h4102, 8'h30, 1'b0, 10, 0, 1'b1, 1'b1);
    n = 0;
    do begin
      step();
      n++;
    end while (!ev_valid && n < 20);
    check("fall_to_valid", n, 4);
    check("t_addr", ev_addr, 16'h4102);
    check("t_dat", ev_dat, 8'h30);
    check("t_rw", ev_rw, 1'b0);
    check("t_cnt", m2_cnt, 16'h1);
    drain();

    for (int i = 0; i < 6; i++) begin
      g0 = gcnt;
      cpu_cycle(tbl[i].addr, tbl[i].dat, tbl[i].rw, tbl[i].hi, 6, tbl[i].ev, tbl[i].ev_r);
      check("glitch_pulses", gcnt - g0, tbl[i].gl);
      cnt_chk();
      drain();
    end

    // five writes into a four-deep FIFO with no consumer
    do_reset(1);
    for (int i = 0; i < 4; i++)
      cpu_cycle(16'h5000 + 16'(i), 8'h10 + 8'(i), 1'b0, 4, 4, 1'b1, 1'b1);
    step();
    check("ovf_before", ev_ovf, 1'b0);
    cpu_cycle(16'h5004, 8'h14, 1'b0, 4, 6, 1'b0, 1'b0);
    check("ovf_after", ev_ovf, 1'b1);
    check("ovf_after_r", ovf_r, 1'b1);
    cnt_chk();
    drain();

    // full FIFO, pop lands on the same edge as the COMMIT push
    do_reset(1);
    for (int i = 0; i < 4; i++)
      cpu_cycle(16'h6000 + 16'(i), 8'h20 + 8'(i), 1'b0, 4, 4, 1'b1, 1'b1);
    cpu_cycle(16'h6004, 8'h24, 1'b0, 4, 0, 1'b1, 1'b1);
    repeat (3) step();
    ev_ready = 1'b1;
    ready_r = 1'b1;
    head_chk();
    step();
    ev_ready = 1'b0;
    ready_r = 1'b0;
    repeat (3) step();
    check("full_pop_ovf", ev_ovf, 1'b0);
    check("full_pop_ovf_r", ovf_r, 1'b0);
    cnt_chk();
    drain();

    // read then write: only the read-enabled instance keeps the read
    do_reset(1);
    cpu_cycle(16'h4100, 8'h99, 1'b1, 4, 5, 1'b0, 1'b1);
    cpu_cycle(16'h8000, 8'h01, 1'b0, 4, 6, 1'b1, 1'b1);
    check("rw_cnt", m2_cnt, 16'h2);
    cnt_chk();
    drain();

    // reset mid-HIGH, remaining high time too short
    do_reset(1);
    cpu_cycle(16'h7000, 8'h01, 1'b0, 4, 4, 1'b1, 1'b1);
    cpu_cycle(16'h7001, 8'h02, 1'b0, 4, 6, 1'b1, 1'b1);
    check("pre_rst_valid", ev_valid, 1'b1);
    cpu_addr = 16'h6000;
    cpu_dat = 8'h42;
    cpu_rw = 1'b0;
    m2 = 1'b1;
    repeat (5) step();
    do_reset(1);
    check("mid_rst_valid", ev_valid, 1'b0);
    check("mid_rst_cnt", m2_cnt, 16'h0);
    check("mid_rst_ovf", ev_ovf, 1'b0);
    g0 = gcnt;
    repeat (2) step();
    m2 = 1'b0;
    repeat (8) step();
    check("short_glitch", gcnt - g0, 1);
    cnt_chk();
    drain();

    // reset mid-HIGH, remaining high time long enough for one event
    m2 = 1'b1;
    repeat (3) step();
    do_reset(1);
    g0 = gcnt;
    q.push_back('{16'h6000, 8'h42, 1'b0});
    qr.push_back('{16'h6000, 8'h42, 1'b0});
    exp_cnt = 1;
    repeat (5) step();
    m2 = 1'b0;
    repeat (6) step();
    check("long_glitch", gcnt - g0, 0);
    cnt_chk();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
